// File: rtl/key_evt_pkg.sv
// Shared definitions for the key event queue: key codes, the S-key hold
// state machine encoding and the pending-slot to code mapping.
package key_evt_pkg;

  localparam int KEY_CODE_W = 3;

  typedef logic [KEY_CODE_W-1:0] key_code_t;

  // Codes 0 and 7 are reserved and never emitted
  localparam key_code_t KEY_A       = 3'd1;
  localparam key_code_t KEY_S_SHORT = 3'd2;
  localparam key_code_t KEY_S_LONG  = 3'd3;
  localparam key_code_t KEY_W       = 3'd4;
  localparam key_code_t KEY_X       = 3'd5;
  localparam key_code_t KEY_D       = 3'd6;

  // Number of pending slots; slot i holds the event whose code is i+1,
  // so a lower slot index means a higher arbitration priority
  localparam int NUM_KEYS = 6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_LONGED = 2'd2
  } s_state_e;

  // Map a pending-slot index to the code pushed into the FIFO
  function automatic key_code_t slot_to_code(input logic [2:0] slot);
    key_code_t code;
    case (slot)
      3'd0:    code = KEY_A;
      3'd1:    code = KEY_S_SHORT;
      3'd2:    code = KEY_S_LONG;
      3'd3:    code = KEY_W;
      3'd4:    code = KEY_X;
      3'd5:    code = KEY_D;
      default: code = '0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/key_event_queue_if.sv
// Valid/ready event channel between the key event queue (master) and the
// control FSM that consumes key codes (slave).
interface key_event_queue_if #(
  parameter int DEPTH = 4
);
  import key_evt_pkg::*;

  logic                         evt_valid;
  logic                         evt_ready;
  logic [KEY_CODE_W-1:0]        evt_code;
  logic [$clog2(DEPTH+1)-1:0]   evt_count;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_count,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_count,
    output evt_ready
  );

endinterface

// File: rtl/key_evt_fifo.sv
// Small synchronous FIFO with a registered head word and registered
// occupancy. A push into a full FIFO is accepted only when a pop happens in
// the same cycle; a pop from an empty FIFO is ignored.
module key_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == OCC_W'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  assign dout  = dout_q;
  assign count = count_q;

  // Next occupancy, read pointer and head word; a push that lands on an
  // empty (or draining-to-empty) FIFO goes straight to the head register
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + OCC_W'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - OCC_W'(1);
    end

    rd_ptr_d = pop_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    dout_d = dout_q;
    if (push_ok && (empty || (pop_ok && count_q == OCC_W'(1)))) begin
      dout_d = din;
    end else if (count_d != '0) begin
      dout_d = mem[rd_ptr_d];
    end
  end

  // Storage array; data words need no reset since occupancy guards them
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= din;
    end
  end

  // Pointers, occupancy and head register; pointers wrap modulo DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// Turns the per-key pulses from the button edge detector into one-cycle
// events, classifies S presses as short or long, and queues the resulting
// key codes for the control FSM over a valid/ready channel.
module key_event_queue
  import key_evt_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int LONG_CYCLES = 100_000_000,
  parameter int CNT_W       = 27
) (
  input  logic clk,
  input  logic buttom_rst,
  input  logic sign_pos_A,
  input  logic sign_pos_S,
  input  logic sign_neg_S,
  input  logic sign_pos_W,
  input  logic sign_pos_X,
  input  logic sign_pos_D,
  input  logic clr_overflow,
  output logic overflow,
  key_event_queue_if.master evt_if
);

  // Counter value at which the press becomes long, and the value just before
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_PRE  = CNT_W'(LONG_CYCLES - 2);

  // Raw input bits: {D, X, W, neg_S, pos_S, A}
  logic [5:0] raw_in, prev_q, edges;
  logic       edge_a, edge_pos_s, edge_neg_s, edge_w, edge_x, edge_d;

  s_state_e         s_state_q, s_state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             short_set, long_set;

  logic [NUM_KEYS-1:0] key_evt, pend_q, pend_d, grant;
  logic [2:0]          sel_slot;
  logic                lost;

  logic                       fifo_push, fifo_full, fifo_empty, pop_now;
  key_code_t                  push_code, fifo_dout;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;

  assign raw_in = {sign_pos_D, sign_pos_X, sign_pos_W,
                   sign_neg_S, sign_pos_S, sign_pos_A};
  assign edges  = raw_in & ~prev_q;

  assign edge_a     = edges[0];
  assign edge_pos_s = edges[1];
  assign edge_neg_s = edges[2];
  assign edge_w     = edges[3];
  assign edge_x     = edges[4];
  assign edge_d     = edges[5];

  // Input history; resets high so a key already held at reset release is not an event
  always_ff @(posedge clk or negedge buttom_rst) begin
    if (!buttom_rst) begin
      prev_q <= '1;
    end else begin
      prev_q <= raw_in;
    end
  end

  // S hold FSM: times the press and decides short vs long; long fires without waiting for release
  always_comb begin
    s_state_d  = s_state_q;
    hold_cnt_d = hold_cnt_q;
    short_set  = 1'b0;
    long_set   = 1'b0;
    case (s_state_q)
      S_IDLE: begin
        if (edge_pos_s) begin
          s_state_d  = S_HOLD;
          hold_cnt_d = '0;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q >= LONG_PRE) begin
          long_set   = 1'b1;
          s_state_d  = S_LONGED;
          hold_cnt_d = LONG_LAST;
        end else if (edge_neg_s) begin
          short_set = 1'b1;
          s_state_d = S_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      S_LONGED: begin
        if (edge_neg_s) begin
          s_state_d = S_IDLE;
        end
      end
      default: begin
        s_state_d  = S_IDLE;
        hold_cnt_d = '0;
      end
    endcase
  end

  // S FSM state and hold counter registers
  always_ff @(posedge clk or negedge buttom_rst) begin
    if (!buttom_rst) begin
      s_state_q  <= S_IDLE;
      hold_cnt_q <= '0;
    end else begin
      s_state_q  <= s_state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // One event bit per code slot, slot order matches arbitration priority
  assign key_evt = {edge_d, edge_x, edge_w, long_set, short_set, edge_a};

  assign pop_now = evt_if.evt_valid & evt_if.evt_ready;

  // Arbiter: push the highest-priority pending code when the FIFO can take it
  always_comb begin
    sel_slot  = '0;
    grant     = '0;
    fifo_push = 1'b0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_slot = 3'(i);
      end
    end
    if ((|pend_q) && (!fifo_full || pop_now)) begin
      fifo_push       = 1'b1;
      grant[sel_slot] = 1'b1;
    end
    push_code = slot_to_code(sel_slot);
    lost      = |(key_evt & pend_q);
    pend_d    = (pend_q & ~grant) | (key_evt & ~pend_q);
  end

  // Pending bits; a repeat edge on a still-pending slot is dropped
  always_ff @(posedge clk or negedge buttom_rst) begin
    if (!buttom_rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Sticky overflow; a new loss outranks a clear in the same cycle
  always_ff @(posedge clk or negedge buttom_rst) begin
    if (!buttom_rst) begin
      overflow <= 1'b0;
    end else if (lost) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  key_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (KEY_CODE_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (buttom_rst),
    .push  (fifo_push),
    .din   (push_code),
    .pop   (evt_if.evt_ready),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_if.evt_valid = ~fifo_empty;
  assign evt_if.evt_code  = fifo_dout;
  assign evt_if.evt_count = fifo_count;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue: a per-cycle vector table for the
// queueing/priority/overflow behaviour plus hand sequences for long holds
// and reset in the middle of a drain.
module tb_key_event_queue;
  import key_evt_pkg::*;

  localparam int DEPTH       = 4;
  localparam int LONG_CYCLES = 50;
  localparam int CNT_W       = 6;

  logic clk = 1'b0;
  logic buttom_rst;
  logic sign_pos_A, sign_pos_S, sign_neg_S;
  logic sign_pos_W, sign_pos_X, sign_pos_D;
  logic clr_overflow;
  logic overflow;

  key_event_queue_if #(.DEPTH(DEPTH)) evt_if ();

  key_event_queue #(
    .DEPTH       (DEPTH),
    .LONG_CYCLES (LONG_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .buttom_rst   (buttom_rst),
    .sign_pos_A   (sign_pos_A),
    .sign_pos_S   (sign_pos_S),
    .sign_neg_S   (sign_neg_S),
    .sign_pos_W   (sign_pos_W),
    .sign_pos_X   (sign_pos_X),
    .sign_pos_D   (sign_pos_D),
    .clr_overflow (clr_overflow),
    .overflow     (overflow),
    .evt_if       (evt_if)
  );

  always #5 clk = ~clk;

  // stim bits: {A, pos_S, neg_S, W, X, D, evt_ready, clr_overflow}
  typedef struct {
    logic [7:0] stim;
    logic       exp_valid;
    logic [2:0] exp_code;
    logic [2:0] exp_count;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  int n_vec  = 0;
  int n_miss = 0;

  // watch counters for the hand-written sequences
  int watch_cycle, watch_events, watch_first;
  logic [2:0] watch_code;

  function automatic vec_t mk(input logic [7:0] stim, input logic v,
                              input logic [2:0] c, input logic [2:0] n,
                              input logic o);
    vec_t r;
    r.stim      = stim;
    r.exp_valid = v;
    r.exp_code  = c;
    r.exp_count = n;
    r.exp_ovf   = o;
    return r;
  endfunction

  task automatic applyStimulus(input logic [7:0] stim);
    @(negedge clk);
    {sign_pos_A, sign_pos_S, sign_neg_S, sign_pos_W,
     sign_pos_X, sign_pos_D, evt_if.evt_ready, clr_overflow} = stim;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic v,
                             input logic [2:0] c, input logic [2:0] n,
                             input logic o);
    n_vec++;
    if (evt_if.evt_valid !== v || evt_if.evt_code !== c ||
        evt_if.evt_count !== n || overflow !== o) begin
      n_miss++;
      $display("[TB] FAIL %s: got valid=%0b code=%0d count=%0d ovf=%0b, expected valid=%0b code=%0d count=%0d ovf=%0b",
               name, evt_if.evt_valid, evt_if.evt_code, evt_if.evt_count,
               overflow, v, c, n, o);
    end
  endtask

  task automatic checkVal(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic watchStart();
    watch_cycle  = 0;
    watch_events = 0;
    watch_first  = -1;
    watch_code   = '0;
  endtask

  task automatic stepWatch(input logic [7:0] stim);
    applyStimulus(stim);
    watch_cycle++;
    if (evt_if.evt_valid) begin
      watch_events++;
      if (watch_first < 0) begin
        watch_first = watch_cycle;
        watch_code  = evt_if.evt_code;
      end
    end
  endtask

  initial begin
    buttom_rst   = 1'b0;
    sign_pos_A   = 1'b1;
    sign_pos_S   = 1'b0;
    sign_neg_S   = 1'b0;
    sign_pos_W   = 1'b0;
    sign_pos_X   = 1'b0;
    sign_pos_D   = 1'b0;
    clr_overflow = 1'b0;
    evt_if.evt_ready = 1'b0;

    // ---- reset with A held high: no event after release ----
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", 1'b0, 3'd0, 3'd0, 1'b0);
    @(negedge clk);
    buttom_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'b1000_0000);
      checkOutput($sformatf("a_held_%0d", i), 1'b0, 3'd0, 3'd0, 1'b0);
    end

    // ---- per-cycle vector table ----
    vecs.push_back(mk(8'b0000_0010, 1'b0, 3'd0, 3'd0, 1'b0)); // A released
    vecs.push_back(mk(8'b0001_0010, 1'b0, 3'd0, 3'd0, 1'b0)); // W edge -> pending
    vecs.push_back(mk(8'b0001_0010, 1'b1, 3'd4, 3'd1, 1'b0)); // W pushed
    vecs.push_back(mk(8'b0001_0010, 1'b0, 3'd4, 3'd0, 1'b0)); // popped, code held
    vecs.push_back(mk(8'b0000_0010, 1'b0, 3'd4, 3'd0, 1'b0));
    vecs.push_back(mk(8'b1000_0100, 1'b0, 3'd4, 3'd0, 1'b0)); // A and D together
    vecs.push_back(mk(8'b1000_0100, 1'b1, 3'd1, 3'd1, 1'b0)); // A first
    vecs.push_back(mk(8'b0000_0000, 1'b1, 3'd1, 3'd2, 1'b0)); // then D
    vecs.push_back(mk(8'b0000_0000, 1'b1, 3'd1, 3'd2, 1'b0));
    vecs.push_back(mk(8'b0000_0010, 1'b1, 3'd6, 3'd1, 1'b0)); // pop A
    vecs.push_back(mk(8'b0000_0010, 1'b0, 3'd6, 3'd0, 1'b0)); // pop D
    vecs.push_back(mk(8'b0100_0000, 1'b0, 3'd6, 3'd0, 1'b0)); // S press
    vecs.push_back(mk(8'b0010_0000, 1'b0, 3'd6, 3'd0, 1'b0)); // S release -> short
    vecs.push_back(mk(8'b0000_0100, 1'b1, 3'd2, 3'd1, 1'b0)); // short pushed, D edge
    vecs.push_back(mk(8'b0000_1000, 1'b1, 3'd2, 3'd2, 1'b0)); // D pushed, X edge
    vecs.push_back(mk(8'b0001_0000, 1'b1, 3'd2, 3'd3, 1'b0)); // X pushed, W edge
    vecs.push_back(mk(8'b1000_0000, 1'b1, 3'd2, 3'd4, 1'b0)); // W pushed, A edge
    vecs.push_back(mk(8'b0000_0000, 1'b1, 3'd2, 3'd4, 1'b0)); // full, A held pending
    vecs.push_back(mk(8'b1000_0001, 1'b1, 3'd2, 3'd4, 1'b1)); // A again lost; set beats clear
    vecs.push_back(mk(8'b0000_0000, 1'b1, 3'd2, 3'd4, 1'b1));
    vecs.push_back(mk(8'b0000_0010, 1'b1, 3'd6, 3'd4, 1'b1)); // pop + push while full
    vecs.push_back(mk(8'b0000_0010, 1'b1, 3'd5, 3'd3, 1'b1));
    vecs.push_back(mk(8'b0000_0010, 1'b1, 3'd4, 3'd2, 1'b1));
    vecs.push_back(mk(8'b0000_0010, 1'b1, 3'd1, 3'd1, 1'b1));
    vecs.push_back(mk(8'b0000_0011, 1'b0, 3'd1, 3'd0, 1'b0)); // last pop, clear overflow
    vecs.push_back(mk(8'b0000_0000, 1'b0, 3'd1, 3'd0, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].stim);
      checkOutput($sformatf("vec_%0d", i), vecs[i].exp_valid,
                  vecs[i].exp_code, vecs[i].exp_count, vecs[i].exp_ovf);
    end

    // ---- W held for 100 cycles: a single event, valid on cycle 2 ----
    watchStart();
    for (int i = 0; i < 100; i++) stepWatch(8'b0001_0010);
    for (int i = 0; i < 5; i++)   stepWatch(8'b0000_0010);
    checkVal("w_hold_events", watch_events, 1);
    checkVal("w_hold_first", watch_first, 2);
    checkVal("w_hold_code", int'(watch_code), int'(KEY_W));

    // ---- S released after 20 cycles: short press ----
    watchStart();
    for (int i = 0; i < 20; i++) stepWatch(8'b0100_0010);
    for (int i = 0; i < 5; i++)  stepWatch(8'b0010_0010);
    for (int i = 0; i < 15; i++) stepWatch(8'b0000_0010);
    checkVal("s_short_events", watch_events, 1);
    checkVal("s_short_first", watch_first, 22);
    checkVal("s_short_code", int'(watch_code), int'(KEY_S_SHORT));

    // ---- S held 80 cycles: long fires while held (pending at cycle 50), nothing on release ----
    watchStart();
    for (int i = 0; i < 80; i++) stepWatch(8'b0100_0010);
    for (int i = 0; i < 5; i++)  stepWatch(8'b0010_0010);
    for (int i = 0; i < 15; i++) stepWatch(8'b0000_0010);
    checkVal("s_long_events", watch_events, 1);
    checkVal("s_long_first", watch_first, 51);
    checkVal("s_long_code", int'(watch_code), int'(KEY_S_LONG));

    // ---- reset mid-drain with three queued events and S held ----
    applyStimulus(8'b1001_1000);
    applyStimulus(8'b1001_1000);
    applyStimulus(8'b1001_1000);
    applyStimulus(8'b1001_1000);
    applyStimulus(8'b1101_1000);
    checkOutput("pre_reset_full3", 1'b1, 3'd1, 3'd3, 1'b0);
    applyStimulus(8'b1101_1010);
    checkOutput("pre_reset_pop", 1'b1, 3'd4, 3'd2, 1'b0);
    @(negedge clk);
    buttom_rst = 1'b0;
    #1;
    checkOutput("async_reset", 1'b0, 3'd0, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    buttom_rst = 1'b1;
    watchStart();
    for (int i = 0; i < 5; i++)  stepWatch(8'b1101_1010);
    for (int i = 0; i < 5; i++)  stepWatch(8'b1011_1010);
    for (int i = 0; i < 60; i++) stepWatch(8'b0000_0010);
    checkVal("post_reset_events", watch_events, 0);
    checkOutput("post_reset_state", 1'b0, 3'd0, 3'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
